// File: rtl/sample_pkg.sv
// Shared types and constants for the pairwise min-sum factor node.
package sample_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_IN = 3'd1,
        ST_CALC1   = 3'd2,
        ST_CALC2   = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

    // Cost-table index {a,b} for psi[a][b]
    localparam logic [1:0] PSI_00 = 2'd0;
    localparam logic [1:0] PSI_01 = 2'd1;
    localparam logic [1:0] PSI_10 = 2'd2;
    localparam logic [1:0] PSI_11 = 2'd3;

endpackage

// File: rtl/sample_minsum.sv
// One message direction: two candidate sums per output state, minimised and
// normalised so the smaller of the two results is zero.
module sample_minsum
    import sample_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W:0]   c0_a,
    input  logic [W:0]   c0_b,
    input  logic [W:0]   c1_a,
    input  logic [W:0]   c1_b,
    output logic [W-1:0] m0,
    output logic [W-1:0] m1
);

    logic [W:0] r0_s;
    logic [W:0] r1_s;
    logic [W:0] rmin_s;

    // Minimum per output state, then subtract the overall minimum; the
    // difference is bounded by the largest cost so it always fits in W bits.
    always_comb begin
        r0_s   = (c0_a < c0_b) ? c0_a : c0_b;
        r1_s   = (c1_a < c1_b) ? c1_a : c1_b;
        rmin_s = (r0_s < r1_s) ? r0_s : r1_s;
        m0     = W'(r0_s - rmin_s);
        m1     = W'(r1_s - rmin_s);
    end

endmodule

// File: rtl/sample_factor.sv
// Pairwise factor node: holds a 2x2 cost table, runs one min-sum message update
// per accepted input set, counts iterations and flags convergence.
module sample_factor
    import sample_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int CONV_CNT = 4,
    parameter int MAX_ITER = 255
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stop,
    input  logic         Pot_we,
    input  logic [1:0]   Pot_addr,
    input  logic [W-1:0] Pot_data,
    input  logic [W-1:0] varA0_in,
    input  logic [W-1:0] varA1_in,
    input  logic [W-1:0] varB0_in,
    input  logic [W-1:0] varB1_in,
    input  logic         In_valid,
    output logic         In_ready,
    output logic [W-1:0] funA0_out,
    output logic [W-1:0] funA1_out,
    output logic [W-1:0] funB0_out,
    output logic [W-1:0] funB1_out,
    output logic         Out_valid,
    output logic         Converged,
    output logic [7:0]   Iter_cnt,
    output logic         Busy
);

    localparam int             SW       = $clog2(CONV_CNT + 1);
    localparam logic [SW-1:0]  STAB_MAX = SW'(CONV_CNT);
    localparam logic [7:0]     ITER_MAX = 8'(MAX_ITER);

    state_e               state_q, state_d;
    logic [3:0][W-1:0]    psi_q, psi_d;
    logic [1:0][W-1:0]    ma_q, ma_d, mb_q, mb_d;
    logic [3:0][W:0]      sa_q, sa_d, sb_q, sb_d;
    logic [1:0][W-1:0]    fa_q, fa_d, fb_q, fb_d;
    logic [1:0][W-1:0]    na_s, nb_s;
    logic                 same_q, same_d;
    logic                 stop_seen_q, stop_seen_d;
    logic [7:0]           iter_q, iter_d, iter_inc_s;
    logic [SW-1:0]        stab_q, stab_d;
    logic                 conv_q, conv_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    sample_minsum #(.W(W)) u_to_b (
        .c0_a (sb_q[PSI_00]), .c0_b (sb_q[PSI_10]),
        .c1_a (sb_q[PSI_01]), .c1_b (sb_q[PSI_11]),
        .m0   (nb_s[0]),      .m1   (nb_s[1])
    );

    sample_minsum #(.W(W)) u_to_a (
        .c0_a (sa_q[PSI_00]), .c0_b (sa_q[PSI_01]),
        .c1_a (sa_q[PSI_10]), .c1_b (sa_q[PSI_11]),
        .m0   (na_s[0]),      .m1   (na_s[1])
    );

    // Next-state, datapath and counter logic for the update sequence
    always_comb begin
        state_d     = state_q;
        psi_d       = psi_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        fa_d        = fa_q;
        fb_d        = fb_q;
        same_d      = same_q;
        stop_seen_d = stop_seen_q;
        iter_d      = iter_q;
        stab_d      = stab_q;
        conv_d      = conv_q;
        iter_inc_s  = (iter_q == ITER_MAX) ? iter_q : iter_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (Pot_we) begin
                    psi_d[Pot_addr] = Pot_data;
                end else begin
                    psi_d = psi_q;
                end
                if (Start) begin
                    state_d = ST_WAIT_IN;
                    iter_d  = 8'd0;
                    stab_d  = '0;
                    conv_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_IN: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else if (In_valid && in_ready_q) begin
                    state_d     = ST_CALC1;
                    ma_d        = {varA1_in, varA0_in};
                    mb_d        = {varB1_in, varB0_in};
                    stop_seen_d = 1'b0;
                end else begin
                    state_d = ST_WAIT_IN;
                end
            end
            ST_CALC1: begin
                sb_d[PSI_00] = {1'b0, psi_q[PSI_00]} + {1'b0, ma_q[0]};
                sb_d[PSI_01] = {1'b0, psi_q[PSI_01]} + {1'b0, ma_q[0]};
                sb_d[PSI_10] = {1'b0, psi_q[PSI_10]} + {1'b0, ma_q[1]};
                sb_d[PSI_11] = {1'b0, psi_q[PSI_11]} + {1'b0, ma_q[1]};
                sa_d[PSI_00] = {1'b0, psi_q[PSI_00]} + {1'b0, mb_q[0]};
                sa_d[PSI_01] = {1'b0, psi_q[PSI_01]} + {1'b0, mb_q[1]};
                sa_d[PSI_10] = {1'b0, psi_q[PSI_10]} + {1'b0, mb_q[0]};
                sa_d[PSI_11] = {1'b0, psi_q[PSI_11]} + {1'b0, mb_q[1]};
                stop_seen_d  = stop_seen_q | Stop;
                state_d      = ST_CALC2;
            end
            ST_CALC2: begin
                fa_d        = na_s;
                fb_d        = nb_s;
                same_d      = (na_s == fa_q) && (nb_s == fb_q);
                stop_seen_d = stop_seen_q | Stop;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                iter_d = iter_inc_s;
                if (same_q) begin
                    stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
                end else begin
                    stab_d = '0;
                end
                conv_d = conv_q | (stab_d == STAB_MAX);
                // A stop raised any time since accept, or hitting the cap, ends the run
                if (stop_seen_q || Stop || (iter_inc_s == ITER_MAX)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_WAIT_IN);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            psi_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            fa_q        <= '0;
            fb_q        <= '0;
            same_q      <= 1'b0;
            stop_seen_q <= 1'b0;
            iter_q      <= 8'd0;
            stab_q      <= '0;
            conv_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            psi_q       <= psi_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            same_q      <= same_d;
            stop_seen_q <= stop_seen_d;
            iter_q      <= iter_d;
            stab_q      <= stab_d;
            conv_q      <= conv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign In_ready  = in_ready_q;
    assign Out_valid = out_valid_q;
    assign Busy      = busy_q;
    assign Converged = conv_q;
    assign Iter_cnt  = iter_q;
    assign funA0_out = fa_q[0];
    assign funA1_out = fa_q[1];
    assign funB0_out = fb_q[0];
    assign funB1_out = fb_q[1];

endmodule
